// File: rtl/cmp_event_ctrl_pkg.sv
// Shared types and defaults for the compare/event controller of the counter/comparator stage.
package cmp_event_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int CW_DEF   = 17;
    localparam int EW_DEF   = 8;
    localparam int QUAL_DEF = 2;
    localparam int QUAL_W   = $clog2(QUAL_DEF + 1);

    function automatic int qual_w(input int qual);
        return $clog2(qual + 1);
    endfunction

endpackage

// File: rtl/cmp_event_ctrl_z_qualifier.sv
// Z glitch qualifier: needs Z low to arm, then QUAL consecutive high samples for an event.
// hit is the combinational qualified sample; evt is its registered one-cycle strobe.
module z_qualifier
    import cmp_event_ctrl_pkg::*;
#(
    parameter int QUAL = QUAL_DEF
) (
    input  logic CK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    input  logic z,
    output logic hit,
    output logic evt
);

    localparam int QW = qual_w(QUAL);

    logic          armed_q, armed_d;
    logic [QW-1:0] qual_q, qual_d;
    logic          evt_q;

    always_comb begin
        hit     = en & ~clr & armed_q & z & (qual_q == QW'(QUAL - 1));
        armed_d = armed_q;
        qual_d  = qual_q;
        if (!en || clr) begin
            armed_d = 1'b0;
            qual_d  = '0;
        end else if (!z) begin
            armed_d = 1'b1;
            qual_d  = '0;
        end else if (hit) begin
            // must see Z low again before the next event can start
            armed_d = 1'b0;
            qual_d  = '0;
        end else if (armed_q) begin
            qual_d  = qual_q + 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            armed_q <= 1'b0;
            qual_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            qual_q  <= qual_d;
            evt_q   <= hit;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/cmp_event_ctrl.sv
// Controller for the counter/comparator stage: loads the compare word, drives count enable,
// counts qualified Z events. Optional compare reload on each event: CMP_EVENT_CTRL_RELOAD_EN.
module cmp_event_ctrl
    import cmp_event_ctrl_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int QUAL = QUAL_DEF,
    parameter int EW   = EW_DEF
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          START,
    input  logic          STOP,
    input  logic [CW-1:0] THRESH,
    input  logic [EW-1:0] N_EVT,
    input  logic          Z_IN,
    output logic          CNT_EN,
    output logic [CW-1:0] CMP,
    output logic          EVT,
    output logic [EW-1:0] EVT_CNT,
    output logic          BUSY,
    output logic          DONE
);

    state_e        state_q, state_d;
    logic [CW-1:0] cmp_q, cmp_d;
    logic [EW-1:0] evt_cnt_q, evt_cnt_d;
    logic          done_q, done_d;
    logic          cnt_en_q, cnt_en_d;
`ifdef CMP_EVENT_CTRL_RELOAD_EN
    logic [CW-1:0] thresh_q, thresh_d;
`endif

    logic          hit;
    logic          evt;
    logic          accept;
    logic          reach;
    logic [EW-1:0] evt_cnt_nxt;

    z_qualifier #(.QUAL(QUAL)) u_zq (
        .CK  (CK),
        .RST (RST),
        .en  (state_q == RUN),
        .clr (STOP),
        .z   (Z_IN),
        .hit (hit),
        .evt (evt)
    );

    always_comb begin
        accept      = (state_q == IDLE) && START && !STOP;
        evt_cnt_nxt = (&evt_cnt_q) ? evt_cnt_q : evt_cnt_q + 1'b1;
        reach       = hit && (N_EVT != '0) && (evt_cnt_nxt == N_EVT);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = STOP ? IDLE : RUN;
            RUN:     if (STOP || reach) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmp_d     = cmp_q;
        evt_cnt_d = evt_cnt_q;
        done_d    = 1'b0;
        cnt_en_d  = (state_d == RUN);
`ifdef CMP_EVENT_CTRL_RELOAD_EN
        thresh_d  = thresh_q;
`endif
        if (accept) begin
            cmp_d     = THRESH;
            evt_cnt_d = '0;
`ifdef CMP_EVENT_CTRL_RELOAD_EN
            thresh_d  = THRESH;
`endif
        end
        // hit is already suppressed by STOP and outside RUN
        if (hit) begin
            evt_cnt_d = evt_cnt_nxt;
            done_d    = reach;
`ifdef CMP_EVENT_CTRL_RELOAD_EN
            cmp_d     = cmp_q + thresh_q;
`endif
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            cmp_q     <= '0;
            evt_cnt_q <= '0;
            done_q    <= 1'b0;
            cnt_en_q  <= 1'b0;
`ifdef CMP_EVENT_CTRL_RELOAD_EN
            thresh_q  <= '0;
`endif
        end else begin
            cmp_q     <= cmp_d;
            evt_cnt_q <= evt_cnt_d;
            done_q    <= done_d;
            cnt_en_q  <= cnt_en_d;
`ifdef CMP_EVENT_CTRL_RELOAD_EN
            thresh_q  <= thresh_d;
`endif
        end
    end

    assign CNT_EN  = cnt_en_q;
    assign CMP     = cmp_q;
    assign EVT     = evt;
    assign EVT_CNT = evt_cnt_q;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;

endmodule

// File: tb/tb_cmp_event_ctrl.sv
// Directed bench for cmp_event_ctrl (CW=17, QUAL=2, EW=8); honours CMP_EVENT_CTRL_RELOAD_EN.
module tb_cmp_event_ctrl;

    logic        CK = 1'b0;
    logic        RST, START, STOP, Z_IN;
    logic [16:0] THRESH;
    logic [7:0]  N_EVT;
    logic        CNT_EN, EVT, BUSY, DONE;
    logic [16:0] CMP;
    logic [7:0]  EVT_CNT;

    int checks = 0;
    int errors = 0;

    cmp_event_ctrl #(.CW(17), .QUAL(2), .EW(8)) dut (
        .CK      (CK),
        .RST     (RST),
        .START   (START),
        .STOP    (STOP),
        .THRESH  (THRESH),
        .N_EVT   (N_EVT),
        .Z_IN    (Z_IN),
        .CNT_EN  (CNT_EN),
        .CMP     (CMP),
        .EVT     (EVT),
        .EVT_CNT (EVT_CNT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // low sample to arm, then two high samples; returns just after the qualifying edge
    task automatic do_evt();
        Z_IN = 1'b0; tick();
        Z_IN = 1'b1; tick();
        Z_IN = 1'b1; tick();
        Z_IN = 1'b0;
    endtask

    logic [16:0] exp_cmp1, exp_cmp2;

    initial begin
        RST = 1'b1; START = 1'b0; STOP = 1'b0; Z_IN = 1'b0;
        THRESH = 17'h5; N_EVT = 8'd0;
        tick(); tick();
        chk("rst_cnt_en", 32'(CNT_EN), 0);
        chk("rst_cmp", 32'(CMP), 0);
        chk("rst_evt", 32'(EVT), 0);
        chk("rst_evt_cnt", 32'(EVT_CNT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        RST = 1'b0;

        // START with STOP: stays idle, compare word not captured
        START = 1'b1; STOP = 1'b1; tick();
        START = 1'b0; STOP = 1'b0;
        chk("startstop_busy", 32'(BUSY), 0);
        chk("startstop_cmp", 32'(CMP), 0);
        tick();
        chk("startstop_busy2", 32'(BUSY), 0);

        // basic run, N_EVT=2
        THRESH = 17'h00010; N_EVT = 8'd2; START = 1'b1; tick();
        START = 1'b0;
        chk("load_busy", 32'(BUSY), 1);
        chk("load_cnt_en", 32'(CNT_EN), 0);
        chk("load_cmp", 32'(CMP), 32'h10);
        tick();
        chk("run_cnt_en", 32'(CNT_EN), 1);
        Z_IN = 1'b0; tick();
        Z_IN = 1'b1; tick();
        chk("basic_first_high_no_evt", 32'(EVT), 0);
        Z_IN = 1'b1; tick();
        chk("basic_evt1", 32'(EVT), 1);
        chk("basic_cnt1", 32'(EVT_CNT), 1);
        chk("basic_done1", 32'(DONE), 0);
        Z_IN = 1'b0; tick();
        chk("basic_evt1_off", 32'(EVT), 0);
        Z_IN = 1'b1; tick();
        Z_IN = 1'b1; tick();
        chk("basic_evt2", 32'(EVT), 1);
        chk("basic_cnt2", 32'(EVT_CNT), 2);
        chk("basic_done2", 32'(DONE), 1);
        chk("basic_cnt_en_off", 32'(CNT_EN), 0);
        chk("basic_busy_off", 32'(BUSY), 0);
        Z_IN = 1'b0; tick();
        chk("basic_done_pulse", 32'(DONE), 0);
        chk("basic_cnt_hold", 32'(EVT_CNT), 2);
        chk("basic_cmp_hold", 32'(CMP), 32'h10);

        // glitch rejection, Z high at RUN entry, N_EVT=0
        N_EVT = 8'd0; Z_IN = 1'b1; START = 1'b1; tick();
        START = 1'b0;
        chk("glitch_cnt_cleared", 32'(EVT_CNT), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("entry_high_no_evt", 32'(EVT), 0);
        end
        for (int i = 0; i < 3; i++) begin
            Z_IN = 1'b0; tick();
            Z_IN = 1'b1; tick();
            Z_IN = 1'b0; tick();
            chk("glitch_no_evt", 32'(EVT), 0);
        end
        chk("glitch_cnt", 32'(EVT_CNT), 0);

        // abort: three events then STOP with the fourth qualifying sample
        for (int i = 1; i <= 3; i++) begin
            do_evt();
            chk("abort_evt", 32'(EVT), 1);
            chk("abort_cnt", 32'(EVT_CNT), 32'(i));
        end
        Z_IN = 1'b0; tick();
        Z_IN = 1'b1; tick();
        STOP = 1'b1; tick();
        STOP = 1'b0; Z_IN = 1'b0;
        chk("abort_no_evt", 32'(EVT), 0);
        chk("abort_cnt_kept", 32'(EVT_CNT), 3);
        chk("abort_no_done", 32'(DONE), 0);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_cnt_en", 32'(CNT_EN), 0);

        // saturation: 300 events with N_EVT=0
        START = 1'b1; tick();
        START = 1'b0; tick();
        chk("sat_cnt_start", 32'(EVT_CNT), 0);
        for (int i = 0; i < 300; i++) do_evt();
        chk("sat_cnt", 32'(EVT_CNT), 255);
        chk("sat_busy", 32'(BUSY), 1);
        chk("sat_cnt_en", 32'(CNT_EN), 1);
        chk("sat_no_done", 32'(DONE), 0);
        STOP = 1'b1; tick();
        STOP = 1'b0;
        chk("sat_stop_busy", 32'(BUSY), 0);

        // reload / constant compare word
`ifdef CMP_EVENT_CTRL_RELOAD_EN
        exp_cmp1 = 17'h1FFE0; exp_cmp2 = 17'h1FFD0;
`else
        exp_cmp1 = 17'h1FFF0; exp_cmp2 = 17'h1FFF0;
`endif
        THRESH = 17'h1FFF0; N_EVT = 8'd2; START = 1'b1; tick();
        START = 1'b0; THRESH = 17'h0;
        chk("reload_cmp0", 32'(CMP), 32'h1FFF0);
        tick();
        do_evt();
        chk("reload_cmp1", 32'(CMP), 32'(exp_cmp1));
        do_evt();
        chk("reload_cmp2", 32'(CMP), 32'(exp_cmp2));
        chk("reload_done", 32'(DONE), 1);
        tick();
        chk("reload_cmp_hold", 32'(CMP), 32'(exp_cmp2));

        // reset mid-run
        N_EVT = 8'd0; THRESH = 17'h123; START = 1'b1; tick();
        START = 1'b0; tick();
        do_evt();
        chk("midrst_cnt_pre", 32'(EVT_CNT), 1);
        RST = 1'b1; tick();
        RST = 1'b0;
        chk("midrst_busy", 32'(BUSY), 0);
        chk("midrst_cnt_en", 32'(CNT_EN), 0);
        chk("midrst_cmp", 32'(CMP), 0);
        chk("midrst_evt", 32'(EVT), 0);
        chk("midrst_cnt", 32'(EVT_CNT), 0);
        chk("midrst_done", 32'(DONE), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
